// File: rtl/cipher_stream_bridge.sv
// Byte-stream <-> block adapter around a block-cipher core, with idle padding.
// Define CBC_MODE_EN to chain blocks (CBC); default build is ECB.
module cipher_stream_bridge #(
  parameter int                       BLOCK_BYTES = 8,
  parameter int                       TIMEOUT     = 100000,
  parameter logic [7:0]               PAD_BYTE    = 8'h00,
  parameter logic [8*BLOCK_BYTES-1:0] IV          = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [8*BLOCK_BYTES-1:0]   c_m_axis_tdata,
  output logic                       c_m_axis_tvalid,
  input  logic                       c_m_axis_tready,
  input  logic [8*BLOCK_BYTES-1:0]   c_s_axis_tdata,
  input  logic                       c_s_axis_tvalid,
  output logic                       c_s_axis_tready,
  output logic                       padded
);
  localparam int BW = 8 * BLOCK_BYTES;
  localparam int IW = $clog2(BLOCK_BYTES);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);

  typedef enum logic [1:0] {FILL, SEND, WAIT, DRAIN} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   idle_q;
  logic [BW-1:0]   blk_q;
  logic [BW-1:0]   out_q;
  logic            pad_q;
  logic            s_beat;
  logic            tmo;

  if (BLOCK_BYTES < 2 || BLOCK_BYTES > 32) begin : g_bad_bb
    $error("BLOCK_BYTES must be in 2..32");
  end

  assign s_axis_tready   = (state_q == FILL);
  assign c_m_axis_tvalid = (state_q == SEND);
  assign c_s_axis_tready = (state_q == WAIT);
  assign m_axis_tvalid   = (state_q == DRAIN);
  assign m_axis_tdata    = out_q[7:0];
  assign padded          = pad_q;

  assign s_beat = s_axis_tvalid & s_axis_tready;
  // An input beat always beats the timeout on the same cycle.
  assign tmo = (TIMEOUT != 0) && (state_q == FILL) && (idx_q != '0)
            && !s_beat && (idle_q == TLIM - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      idle_q  <= '0;
      blk_q   <= '0;
      out_q   <= '0;
      pad_q   <= 1'b0;
    end else begin
      pad_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (s_beat) begin
            blk_q[8*idx_q +: 8] <= s_axis_tdata;
            idle_q <= '0;
            idx_q  <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
            if (idx_q == LAST) state_q <= SEND;
          end else if (tmo) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (IW'(i) >= idx_q) blk_q[8*i +: 8] <= PAD_BYTE;
            end
            idx_q   <= '0;
            idle_q  <= '0;
            pad_q   <= 1'b1;
            state_q <= SEND;
          end else if (idx_q != '0 && idle_q != TLIM) begin
            idle_q <= idle_q + 1'b1;
          end
        end
        SEND: begin
          if (c_m_axis_tready) state_q <= WAIT;
        end
        WAIT: begin
          if (c_s_axis_tvalid) begin
            out_q   <= c_s_axis_tdata;
            idx_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_axis_tready) begin
            out_q <= out_q >> 8;
            idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
            if (idx_q == LAST) state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

`ifdef CBC_MODE_EN
  logic [BW-1:0] chain_q;

  // Chain value is the previous ciphertext returned by the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= IV;
    end else if (state_q == WAIT && c_s_axis_tvalid) begin
      chain_q <= c_s_axis_tdata;
    end
  end

  assign c_m_axis_tdata = blk_q ^ chain_q;
`else
  if ($bits(IV) != BW) begin : g_bad_iv
    $error("IV width must equal block width");
  end

  assign c_m_axis_tdata = blk_q;
`endif

endmodule

// File: tb/tb_cipher_stream_bridge.sv
// Bench for cipher_stream_bridge: vector table, corner sequences, random run.
// A block-level model (packing, chaining, core function) predicts all results.
module tb_cipher_stream_bridge;
  localparam logic [63:0] IVV = 64'h0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic [63:0]  c_m_axis_tdata;
  logic         c_m_axis_tvalid;
  logic         c_m_axis_tready = 1'b1;
  logic [63:0]  c_s_axis_tdata = '0;
  logic         c_s_axis_tvalid = 1'b0;
  logic         c_s_axis_tready;
  logic         padded;

  logic [7:0]   d2_s_tdata = '0;
  logic         d2_s_tvalid = 1'b0;
  logic         d2_s_tready;
  logic [7:0]   d2_m_tdata;
  logic         d2_m_tvalid;
  logic         d2_m_tready = 1'b0;
  logic [127:0] d2_c_m_tdata;
  logic         d2_c_m_tvalid;
  logic         d2_c_m_tready = 1'b0;
  logic [127:0] d2_c_s_tdata = '0;
  logic         d2_c_s_tvalid = 1'b0;
  logic         d2_c_s_tready;
  logic         d2_padded;

  always #5 clk = ~clk;

  cipher_stream_bridge #(
    .BLOCK_BYTES(8), .TIMEOUT(16), .PAD_BYTE(8'hA5), .IV(IVV)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tvalid(c_m_axis_tvalid),
    .c_m_axis_tready(c_m_axis_tready),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tvalid(c_s_axis_tvalid),
    .c_s_axis_tready(c_s_axis_tready),
    .padded(padded)
  );

  cipher_stream_bridge #(
    .BLOCK_BYTES(16), .TIMEOUT(0), .PAD_BYTE(8'hA5), .IV(128'h0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(d2_s_tdata), .s_axis_tvalid(d2_s_tvalid),
    .s_axis_tready(d2_s_tready),
    .m_axis_tdata(d2_m_tdata), .m_axis_tvalid(d2_m_tvalid),
    .m_axis_tready(d2_m_tready),
    .c_m_axis_tdata(d2_c_m_tdata), .c_m_axis_tvalid(d2_c_m_tvalid),
    .c_m_axis_tready(d2_c_m_tready),
    .c_s_axis_tdata(d2_c_s_tdata), .c_s_axis_tvalid(d2_c_s_tvalid),
    .c_s_axis_tready(d2_c_s_tready),
    .padded(d2_padded)
  );

  typedef struct {
    int          n;
    logic [63:0] din;
    logic [63:0] blk;
    bit          pad;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int viol = 0;

  logic [63:0] core_xor = '0;
  logic [63:0] core_buf = '0;
  bit          core_pend = 1'b0;
  logic [63:0] chain_m = IVV;
  logic [63:0] cm_q[$];
  logic [7:0]  out_q[$];
  logic [7:0]  inq[$];

  int cyc_n = 0;
  int last_beat = 0;
  int pad_cyc = 0;
  int pad_cnt = 0;
  int cmv_cyc = 0;
  int cmhs_cyc = 0;
  int cshs_cyc = 0;
  int mv_cyc = 0;
  int cm_hold = 0;
  int m_mode = 0;
  bit rand_ready = 1'b0;
  bit s_beat, d2_beat;
  bit d2_cmv_seen = 1'b0;
  bit d2_pad_seen = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] enc_in(logic [63:0] blk);
`ifdef CBC_MODE_EN
    return blk ^ chain_m;
`else
    return blk;
`endif
  endfunction

  // One clock: record handshakes, step, check protocol, drive next inputs.
  task automatic cyc();
    bit pm_stall, pc_stall, pcmv, pmv;
    logic [7:0]  pm_data;
    logic [63:0] pc_data;
    s_beat  = s_axis_tvalid && s_axis_tready;
    d2_beat = d2_s_tvalid && d2_s_tready;
    if (s_beat) last_beat = cyc_n;
    if (c_m_axis_tvalid && c_m_axis_tready) begin
      cm_q.push_back(c_m_axis_tdata);
      core_buf  = c_m_axis_tdata ^ core_xor;
      core_pend = 1'b1;
      cmhs_cyc  = cyc_n;
    end
    if (c_s_axis_tvalid && c_s_axis_tready) begin
      core_pend = 1'b0;
      cshs_cyc  = cyc_n;
    end
    if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);
    pm_stall = m_axis_tvalid && !m_axis_tready;
    pm_data  = m_axis_tdata;
    pc_stall = c_m_axis_tvalid && !c_m_axis_tready;
    pc_data  = c_m_axis_tdata;
    pcmv     = c_m_axis_tvalid;
    pmv      = m_axis_tvalid;
    @(posedge clk);
    #1;
    cyc_n++;
    if (!rst) begin
      if (pm_stall && (!m_axis_tvalid || m_axis_tdata !== pm_data)) viol++;
      if (pc_stall && (!c_m_axis_tvalid || c_m_axis_tdata !== pc_data)) viol++;
      if (s_axis_tready && (c_m_axis_tvalid || c_s_axis_tready || m_axis_tvalid))
        viol++;
      if (int'(c_m_axis_tvalid) + int'(c_s_axis_tready) + int'(m_axis_tvalid) > 1)
        viol++;
    end
    if (padded) begin
      pad_cnt++;
      pad_cyc = cyc_n;
    end
    if (c_m_axis_tvalid && !pcmv) cmv_cyc = cyc_n;
    if (m_axis_tvalid && !pmv) mv_cyc = cyc_n;
    if (d2_c_m_tvalid) d2_cmv_seen = 1'b1;
    if (d2_padded) d2_pad_seen = 1'b1;
    c_s_axis_tvalid = core_pend;
    c_s_axis_tdata  = core_buf;
    if (cm_hold > 0) begin
      c_m_axis_tready = 1'b0;
      cm_hold--;
    end else begin
      c_m_axis_tready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end
    case (m_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = !m_axis_tready;
      default: m_axis_tready = 1'($urandom % 2);
    endcase
  endtask

  task automatic send_byte(logic [7:0] b);
    int t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    do begin
      cyc();
      t++;
    end while (!s_beat && t < 500);
    s_axis_tvalid = 1'b0;
    if (!s_beat) begin
      checks++;
      errors++;
      $display("FAIL send_byte: byte %0h not accepted in %0d cycles", b, t);
    end
  endtask

  task automatic send_d2(logic [7:0] b);
    int t = 0;
    d2_s_tvalid = 1'b1;
    d2_s_tdata  = b;
    do begin
      cyc();
      t++;
    end while (!d2_beat && t < 50);
    d2_s_tvalid = 1'b0;
    if (!d2_beat) begin
      checks++;
      errors++;
      $display("FAIL send_d2: byte %0h not accepted in %0d cycles", b, t);
    end
  endtask

  task automatic wait_out(int n);
    int t = 0;
    while (out_q.size() < n && t < 5000) begin
      cyc();
      t++;
    end
    if (out_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_out: got %0d bytes, expected %0d", out_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    cm_hold = 0;
    cyc();
    cyc();
    rst = 1'b0;
    chain_m = IVV;
    core_pend = 1'b0;
    c_s_axis_tvalid = 1'b0;
  endtask

  // Check block count/value and all output bytes against the model.
  task automatic check_blocks(string tag, int nblk);
    logic [63:0] blk, exp, res;
    int bad = 0;
    chk({tag, "_nblk"}, cm_q.size(), nblk);
    chk({tag, "_nbytes"}, out_q.size(), 8 * nblk);
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int k = 0; k < 8; k++) blk[8*k +: 8] = inq[8*b + k];
      exp = enc_in(blk);
      res = exp ^ core_xor;
      chain_m = res;
      chk($sformatf("%s_blk%0d", tag, b),
          (b < cm_q.size()) ? cm_q[b] : 64'hx, exp);
      for (int k = 0; k < 8; k++)
        if ((8*b + k >= out_q.size()) || out_q[8*b + k] !== res[8*k +: 8]) bad++;
    end
    chk({tag, "_bytes_bad"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[5];
    logic [63:0] exp, res, exp_id;
    logic [7:0]  v8;
    int          bad;

    tv[0] = '{8, 64'h0706050403020100, 64'h0706050403020100, 1'b0};
    tv[1] = '{3, 64'h0000000000332211, 64'hA5A5A5A5A5332211, 1'b1};
    tv[2] = '{1, 64'h00000000000000EE, 64'hA5A5A5A5A5A5A5EE, 1'b1};
    tv[3] = '{7, 64'h0077665544332211, 64'hA577665544332211, 1'b1};
    tv[4] = '{8, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 1'b0};

    do_reset();
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_cm_tvalid", c_m_axis_tvalid, 0);
    chk("rst_cs_tready", c_s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_padded", padded, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_cm_tdata", c_m_axis_tdata, enc_in(64'h0));
    chk("rst_d2_cm_tvalid", d2_c_m_tvalid, 0);
    cyc();
    chk("post_rst_cm_tvalid", c_m_axis_tvalid, 0);
    chk("post_rst_m_tvalid", m_axis_tvalid, 0);

    core_xor = '1;
    for (int v = 0; v < 5; v++) begin
      out_q.delete();
      cm_q.delete();
      pad_cnt = 0;
      for (int k = 0; k < tv[v].n; k++) send_byte(tv[v].din[8*k +: 8]);
      wait_out(8);
      exp = enc_in(tv[v].blk);
      res = exp ^ core_xor;
      chain_m = res;
      chk($sformatf("vec%0d_block", v), (cm_q.size() > 0) ? cm_q[0] : 64'hx, exp);
      chk($sformatf("vec%0d_pad_pulses", v), pad_cnt, tv[v].pad);
      if (tv[v].pad) begin
        chk($sformatf("vec%0d_pad_delay", v), pad_cyc - last_beat, 17);
        chk($sformatf("vec%0d_send_on_pad", v), cmv_cyc, pad_cyc);
      end else begin
        chk($sformatf("vec%0d_send_lat", v), cmv_cyc - last_beat, 1);
      end
      chk($sformatf("vec%0d_out_lat", v), mv_cyc - cshs_cyc, 1);
      bad = 0;
      for (int k = 0; k < 8; k++)
        if (k >= out_q.size() || out_q[k] !== res[8*k +: 8]) bad++;
      chk($sformatf("vec%0d_bytes_bad", v), bad, 0);
    end

    out_q.delete();
    cm_q.delete();
    inq.delete();
    cm_hold = 100000;
    c_m_axis_tready = 1'b0;
    m_mode = 1;
    for (int k = 0; k < 8; k++) begin
      inq.push_back(8'(k));
      send_byte(8'(k));
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_axis_tready || !c_m_axis_tvalid) bad++;
    end
    chk("stall_hold_bad", bad, 0);
    chk("stall_no_hs", cm_q.size(), 0);
    cm_hold = 0;
    wait_out(8);
    repeat (6) cyc();
    check_blocks("stall", 1);
    m_mode = 0;

    do_reset();
    out_q.delete();
    cm_q.delete();
    inq.delete();
    core_xor = '0;
    for (int k = 0; k < 16; k++) begin
      inq.push_back(8'h00);
      send_byte(8'h00);
    end
    wait_out(16);
`ifdef CBC_MODE_EN
    exp_id = IVV;
`else
    exp_id = 64'h0;
`endif
    chk("ident_blk0", (cm_q.size() > 0) ? cm_q[0] : 64'hx, exp_id);
    chk("ident_blk1", (cm_q.size() > 1) ? cm_q[1] : 64'hx, exp_id);
    check_blocks("ident", 2);

    out_q.delete();
    cm_q.delete();
    inq.delete();
    pad_cnt = 0;
    core_xor = {$urandom, $urandom};
    rand_ready = 1'b1;
    m_mode = 2;
    for (int i = 0; i < 24 * 8; i++) begin
      v8 = 8'($urandom);
      inq.push_back(v8);
      repeat ($urandom_range(0, 3)) cyc();
      send_byte(v8);
    end
    wait_out(24 * 8);
    check_blocks("rnd", 24);
    chk("rnd_no_pad", pad_cnt, 0);
    rand_ready = 1'b0;
    m_mode = 0;

    for (int k = 0; k < 5; k++) send_byte(8'hC0 + 8'(k));
    do_reset();
    cyc();
    chk("midrst_cm_tvalid", c_m_axis_tvalid, 0);
    chk("midrst_m_tvalid", m_axis_tvalid, 0);
    chk("midrst_s_tready", s_axis_tready, 1);
    chk("midrst_cm_tdata", c_m_axis_tdata, enc_in(64'h0));
    out_q.delete();
    cm_q.delete();
    inq.delete();
    for (int k = 0; k < 8; k++) begin
      inq.push_back(8'h80 + 8'(k));
      send_byte(8'h80 + 8'(k));
    end
    wait_out(8);
    chk("midrst_block", (cm_q.size() > 0) ? cm_q[0] : 64'hx,
        enc_in(64'h8786858483828180));
    check_blocks("midrst", 1);

    for (int k = 0; k < 15; k++) send_d2(8'(k));
    d2_cmv_seen = 1'b0;
    d2_pad_seen = 1'b0;
    repeat (10000) cyc();
    chk("d2_no_send", d2_cmv_seen, 0);
    chk("d2_no_pad", d2_pad_seen, 0);
    send_d2(8'h0F);
    chk("d2_send_valid", d2_c_m_tvalid, 1);
    chk("d2_block", d2_c_m_tdata, 128'h0F0E0D0C0B0A09080706050403020100);

    chk("protocol_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
